hs_arbiter: RTL and testbench

HS_ARBITER -- requirements
Module: hs_arbiter

---
 rtl/hs_arbiter.sv | 165 ++++++++++++++++
 tb/tb_hs_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_arbiter.sv
// ---------------------------------------------------------------------------
// hs_arbiter
//
// Round-robin front end that lets N_REQ requesters share one pipelined
// hardswish segment. One sample is accepted per cycle, forwarded to the
// segment on the following cycle, and its requester index travels alongside
// in a HS_LATENCY-deep tag pipeline so the returning result can be steered
// back to its owner.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous reset, active-low
//   req_valid  per-requester sample valid                  [N_REQ]
//   req_data   requester i at [i*DATA_WIDTH +: DATA_WIDTH]  [N_REQ*DATA_WIDTH]
//   req_ready  combinational one-hot accept                [N_REQ]
//   hold       suppresses new grants while high
//   hs_en      issue strobe to the hardswish segment
//   hs_data    sample to the hardswish segment             [DATA_WIDTH]
//   hs_valid   result strobe from the hardswish segment
//   hs_result  result from the hardswish segment           [OUT_WIDTH]
//   rsp_valid  one-hot result pulse to the owning requester [N_REQ]
//   rsp_data   result, shared by all requesters             [OUT_WIDTH]
//   rsp_tag    index of the owning requester                [TAG_W]
//   busy       hs_en or any issue still in flight
//   err        sticky result/tag misalignment flag
// ---------------------------------------------------------------------------
module hs_arbiter #(
    parameter int  DATA_WIDTH = 26,
    parameter int  OUT_WIDTH  = 14,
    parameter int  N_REQ      = 4,
    parameter int  HS_LATENCY = 5,
    localparam int TAG_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        hold,
    output logic                        hs_en,
    output logic [DATA_WIDTH-1:0]       hs_data,
    input  logic                        hs_valid,
    input  logic [OUT_WIDTH-1:0]        hs_result,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [OUT_WIDTH-1:0]        rsp_data,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic                        busy,
    output logic                        err
);

    logic [TAG_W-1:0]      rr_ptr;
    logic                  grant_found;
    logic [TAG_W-1:0]      grant_idx;
    logic [TAG_W-1:0]      cand;
    logic                  transfer;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [TAG_W-1:0]      issue_tag;

    logic                  pipe_v [HS_LATENCY];
    logic [TAG_W-1:0]      pipe_t [HS_LATENCY];
    logic                  exp_v;
    logic [TAG_W-1:0]      exp_t;
    logic                  inflight;

    // Search upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = TAG_W'((32'(rr_ptr) + off) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Grants are withheld during the reset cycle as well as under hold.
    always_comb begin
        req_ready = '0;
        transfer  = 1'b0;
        if (rst && !hold && grant_found) begin
            req_ready[grant_idx] = 1'b1;
            transfer             = 1'b1;
        end
    end

    always_comb begin
        sel_data = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pointer and issue register
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr    <= '0;
            hs_en     <= 1'b0;
            hs_data   <= '0;
            issue_tag <= '0;
        end else begin
            hs_en <= transfer;
            if (transfer) begin
                hs_data   <= sel_data;
                issue_tag <= grant_idx;
                if (grant_idx == TAG_W'(N_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end
        end
    end

    // Tag pipeline: stage 0 captures the issue in the cycle hs_en is high,
    // so the last stage lines up with the segment's hs_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < HS_LATENCY; k++) begin
                pipe_v[k] <= 1'b0;
                pipe_t[k] <= '0;
            end
        end else begin
            pipe_v[0] <= hs_en;
            pipe_t[0] <= issue_tag;
            for (int unsigned k = 1; k < HS_LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_t[k] <= pipe_t[k-1];
            end
        end
    end

    always_comb begin
        exp_v = pipe_v[HS_LATENCY-1];
        exp_t = pipe_t[HS_LATENCY-1];
    end

    always_comb begin
        inflight = 1'b0;
        for (int unsigned k = 0; k < HS_LATENCY; k++) begin
            inflight = inflight | pipe_v[k];
        end
        busy = hs_en | inflight;
    end

    // Response steering and misalignment detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            err       <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (exp_v && hs_valid) begin
                rsp_valid[exp_t] <= 1'b1;
                rsp_tag          <= exp_t;
                rsp_data         <= hs_result;
            end
            if (exp_v != hs_valid) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hs_arbiter.sv
module tb_hs_arbiter;

    localparam int DW = 26;
    localparam int OW = 14;
    localparam int N  = 4;
    localparam int L  = 5;
    localparam int TW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              hold;
    logic              hs_en;
    logic [DW-1:0]     hs_data;
    logic              hs_valid;
    logic [OW-1:0]     hs_result;
    logic [N-1:0]      rsp_valid;
    logic [OW-1:0]     rsp_data;
    logic [TW-1:0]     rsp_tag;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    hs_arbiter #(
        .DATA_WIDTH(DW),
        .OUT_WIDTH (OW),
        .N_REQ     (N),
        .HS_LATENCY(L)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .hold     (hold),
        .hs_en    (hs_en),
        .hs_data  (hs_data),
        .hs_valid (hs_valid),
        .hs_result(hs_result),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_tag  (rsp_tag),
        .busy     (busy),
        .err      (err)
    );

    int errors = 0;
    int checks = 0;

    // Staged stimulus, applied at the next falling edge
    logic            s_rst   = 1'b0;
    logic [N-1:0]    s_valid = '0;
    logic [N*DW-1:0] s_data  = '0;
    logic            s_hold  = 1'b0;
    bit              s_spur  = 0;
    bit              s_drop  = 0;

    // Reference model: outstanding issues with the cycle their result is due
    typedef struct {
        int tag;
        int due;
    } flight_t;

    flight_t         fl[$];
    int              cyc = 0;
    int              m_ptr = 0;
    bit              m_hs_en = 0;
    logic [DW-1:0]   m_hs_data = '0;
    logic [N-1:0]    m_rsp_valid = '0;
    logic [OW-1:0]   m_rsp_data = '0;
    int              m_rsp_tag = 0;
    bit              m_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Winner = valid requester with the smallest forward distance from ptr.
    function automatic int m_grant(input logic [N-1:0] v, input logic h, input logic r, input int ptr);
        int best  = -1;
        int bestd = N;
        if (h || !r) return -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                int d = (i - ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic int due_index();
        for (int i = 0; i < fl.size(); i++)
            if (fl[i].due == cyc) return i;
        return -1;
    endfunction

    // An issue occupies hs_en at due-L and the tag pipeline through due.
    function automatic bit m_busy();
        foreach (fl[i])
            if (fl[i].due - L <= cyc && cyc <= fl[i].due) return 1;
        return 0;
    endfunction

    task automatic compare();
        int g;
        logic [N-1:0] one = 1;
        logic [N-1:0] exp_ready;
        g = m_grant(req_valid, hold, rst, m_ptr);
        exp_ready = (g >= 0) ? (one << g) : '0;
        chk("req_ready", req_ready, exp_ready);
        chk("hs_en", hs_en, m_hs_en);
        if (m_hs_en) chk("hs_data", hs_data, m_hs_data);
        chk("rsp_valid", rsp_valid, m_rsp_valid);
        chk("rsp_data", rsp_data, m_rsp_data);
        chk("rsp_tag", rsp_tag, m_rsp_tag);
        chk("busy", busy, m_busy());
        chk("err", err, m_err);
    endtask

    task automatic advance(input int di);
        int g;
        logic [N-1:0] one = 1;
        if (!rst) begin
            fl.delete();
            m_ptr = 0; m_hs_en = 0; m_hs_data = '0;
            m_rsp_valid = '0; m_rsp_data = '0; m_rsp_tag = 0; m_err = 0;
            cyc++;
            return;
        end
        g = m_grant(req_valid, hold, rst, m_ptr);
        if (di >= 0 && hs_valid) begin
            m_rsp_valid = one << fl[di].tag;
            m_rsp_tag   = fl[di].tag;
            m_rsp_data  = hs_result;
        end else begin
            m_rsp_valid = '0;
        end
        if ((di >= 0) != hs_valid) m_err = 1;
        if (di >= 0) fl.delete(di);
        if (g >= 0) begin
            m_hs_en   = 1;
            m_hs_data = req_data[g*DW +: DW];
            fl.push_back('{tag: g, due: cyc + 1 + L});
            m_ptr = (g + 1) % N;
        end else begin
            m_hs_en = 0;
        end
        cyc++;
    endtask

    // One clock cycle: drive at the falling edge, the segment stub answers
    // from the model's due list, then compare and advance the model.
    task automatic tick();
        int di;
        @(negedge clk);
        rst       = s_rst;
        req_valid = s_valid;
        req_data  = s_data;
        hold      = s_hold;
        di        = due_index();
        hs_valid  = (di >= 0) ? !s_drop : s_spur;
        hs_result = OW'($urandom);
        s_spur = 0;
        s_drop = 0;
        #1;
        compare();
        advance(di);
    endtask

    task automatic do_reset();
        s_rst = 1'b0; s_valid = '0; s_hold = 1'b0;
        tick(); tick();
        s_rst = 1'b1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] r6;
        int q_tags[$];
        int hen;
        int rsp_cnt;
        bit bz[16];
        bit hv[16];
        int last;
        int lat;
        int got_tag;

        rst = 1'b0; req_valid = '0; req_data = '0; hold = 1'b0;
        hs_valid = 1'b0; hs_result = '0;

        // Reset state
        do_reset();
        chk("reset_hs_en", hs_en, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_err", err, 0);
        chk("reset_busy", busy, 0);

        // Single requester, 1.0 in -> response at cycle 7
        s_data = '0;
        s_data[0 +: DW] = 26'd512;
        s_valid = 4'b0001;
        tick();
        chk("single_ready", req_ready, 4'b0001);
        s_valid = '0;
        tick();
        chk("single_hs_en", hs_en, 1);
        chk("single_hs_data", hs_data, 512);
        repeat (5) tick();
        chk("single_hs_valid_c6", hs_valid, 1);
        r6 = hs_result;
        tick();
        chk("single_rsp_valid", rsp_valid, 4'b0001);
        chk("single_rsp_tag", rsp_tag, 0);
        chk("single_rsp_data", rsp_data, r6);

        // All four continuously valid for 8 cycles
        do_reset();
        s_valid = 4'b1111;
        hen = 0;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            tick();
            chk("rr_order", req_ready, 4'b0001 << (i % 4));
            if (hs_en) hen++;
            if (|rsp_valid) q_tags.push_back(int'(rsp_tag));
        end
        s_valid = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (hs_en) hen++;
            if (|rsp_valid) q_tags.push_back(int'(rsp_tag));
        end
        chk("rr_hs_en_count", hen, 8);
        chk("rr_rsp_count", q_tags.size(), 8);
        for (int i = 0; i < q_tags.size() && i < 8; i++)
            chk("rr_rsp_tag_order", q_tags[i], i % 4);

        // Wrap-around search from rr_ptr = 2
        do_reset();
        s_valid = 4'b0010;
        tick();
        chk("wrap_setup", req_ready, 4'b0010);
        s_valid = 4'b0011;
        tick();
        chk("wrap_grant0", req_ready, 4'b0001);
        tick();
        chk("wrap_grant1", req_ready, 4'b0010);
        s_valid = '0;
        repeat (10) tick();

        // Hold after three transfers
        do_reset();
        s_valid = 4'b1111;
        repeat (3) begin rand_data(); tick(); end
        s_valid = '0;
        repeat (2) tick();
        s_hold = 1'b1;
        s_valid = 4'b1111;
        rsp_cnt = 0;
        last = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) chk("hold_ready", req_ready, 0);
            bz[i] = busy;
            hv[i] = hs_valid;
            if (hs_valid) last = i;
            if (|rsp_valid) rsp_cnt++;
        end
        chk("hold_rsp_count", rsp_cnt, 3);
        chk("hold_last_hs_valid", last, 3);
        if (last >= 0 && last < 11) begin
            chk("hold_busy_at_last", bz[last], 1);
            chk("hold_busy_after", bz[last+1], 0);
        end
        s_hold = 1'b0;
        s_valid = '0;
        tick();

        // Spurious hs_valid with an empty tag pipeline
        do_reset();
        tick();
        s_spur = 1;
        tick();
        chk("spur_hs_valid", hs_valid, 1);
        tick();
        chk("spur_err", err, 1);
        chk("spur_no_rsp", rsp_valid, 0);
        repeat (3) tick();
        chk("spur_err_sticky", err, 1);
        s_rst = 1'b0;
        tick();
        s_rst = 1'b1;
        tick();
        chk("spur_err_cleared", err, 0);

        // Reset with issues in flight, then a fresh transfer
        do_reset();
        s_valid = 4'b1111;
        repeat (3) begin rand_data(); tick(); end
        s_valid = '0;
        repeat (2) tick();
        s_rst = 1'b0;
        tick();
        s_rst = 1'b1;
        tick();
        chk("flush_hs_en", hs_en, 0);
        chk("flush_rsp_valid", rsp_valid, 0);
        chk("flush_rsp_data", rsp_data, 0);
        chk("flush_rsp_tag", rsp_tag, 0);
        chk("flush_busy", busy, 0);
        chk("flush_err", err, 0);
        rsp_cnt = 0;
        repeat (8) begin tick(); if (|rsp_valid) rsp_cnt++; end
        chk("flush_dropped", rsp_cnt, 0);
        s_valid = 4'b0100;
        rand_data();
        tick();
        s_valid = '0;
        lat = -1;
        got_tag = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (|rsp_valid && lat < 0) begin
                lat = k;
                got_tag = int'(rsp_tag);
            end
        end
        chk("flush_new_latency", lat, 7);
        chk("flush_new_tag", got_tag, 2);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s_valid = N'($urandom);
            s_hold  = ($urandom_range(0, 4) == 0);
            rand_data();
            s_rst   = ($urandom_range(0, 99) != 0);
            s_spur  = ($urandom_range(0, 199) == 0);
            s_drop  = ($urandom_range(0, 199) == 0);
            tick();
        end
        s_rst = 1'b1; s_valid = '0; s_hold = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
